// File: rtl/burst_memory.sv
// burst_memory: byte-addressable memory with 1/4/8/16-word read/write bursts and a busy handshake
// Ports: clock, reset (sync, active-high); address/rw/access_size/enable form a command taken when
// idle; data_in is written on every write beat; data_out/data_valid carry big-endian read beats;
// busy is high while the remaining beats of a burst run. Define BURST_MEMORY_WRAP_EN for
// critical-word-first wrapping within the aligned burst block.
module burst_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH = 1048576
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            access_size,
  input  logic                  rw,
  input  logic                  enable,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid
);
  localparam int BPW = DATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [4:0] count_q, count_d, len;
  logic [1:0] size_q, cur_size;
  logic rw_q, accept, beat, beat_rw;
  logic [ADDR_WIDTH-1:0] addr_q, beat_addr, step_addr, next_addr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [7:0] mem [DEPTH];
`ifdef BURST_MEMORY_WRAP_EN
  logic [ADDR_WIDTH-1:0] base_q, base_addr, mask;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q <= '0;
      size_q <= '0;
      rw_q <= 1'b0;
      data_out <= '0;
      data_valid <= 1'b0;
`ifdef BURST_MEMORY_WRAP_EN
      base_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (beat) addr_q <= next_addr;
      if (accept) begin
        size_q <= access_size;
        rw_q <= rw;
`ifdef BURST_MEMORY_WRAP_EN
        base_q <= address;
`endif
      end
      data_valid <= beat && !beat_rw;
      if (beat && !beat_rw) data_out <= rd_word;
    end
  end
  // A reset edge performs no beat, so the write port is gated by reset too.
  always_ff @(posedge clock) begin
    if (!reset && beat && beat_rw)
      for (int k = 0; k < BPW; k++)
        mem[AW'(beat_addr + ADDR_WIDTH'(k))] <= data_in[DATA_WIDTH-1-8*k -: 8];
  end
  always_comb begin
    state_d = accept ? (len > 5'd1 ? BURST : IDLE) : (busy && count_q == 5'd1 ? IDLE : state_q);
    count_d = accept ? len - 5'd1 : (busy ? count_q - 5'd1 : count_q);
`ifdef BURST_MEMORY_WRAP_EN
    mask = ADDR_WIDTH'(len) * ADDR_WIDTH'(BPW) - ADDR_WIDTH'(1);
    next_addr = (base_addr & ~mask) | (step_addr & mask);
`else
    next_addr = step_addr;
`endif
  end
  // Beat 0 happens on the accept edge, so command fields bypass their latches then.
  always_comb begin
    busy = state_q == BURST;
    accept = state_q == IDLE && enable;
    beat = accept || busy;
    beat_rw = accept ? rw : rw_q;
    beat_addr = accept ? address : addr_q;
    cur_size = accept ? access_size : size_q;
    len = cur_size == 2'd0 ? 5'd1 : 5'd1 << ({1'b0, cur_size} + 3'd1);
    step_addr = beat_addr + ADDR_WIDTH'(BPW);
`ifdef BURST_MEMORY_WRAP_EN
    base_addr = accept ? address : base_q;
`endif
    rd_word = '0;
    for (int k = 0; k < BPW; k++)
      rd_word[DATA_WIDTH-1-8*k -: 8] = mem[AW'(beat_addr + ADDR_WIDTH'(k))];
  end
endmodule

// File: tb/tb_burst_memory.sv
// tb_burst_memory: scoreboard bench for burst_memory against a byte-array model
module tb_burst_memory;
  localparam int DW = 32;
  localparam int AWID = 32;
  localparam int DEPTH = 4096;
  localparam int BPW = DW / 8;
  logic clk = 1'b0, reset = 1'b1, rw = 1'b0, enable = 1'b0;
  logic [AWID-1:0] address = '0;
  logic [DW-1:0] data_in = '0;
  logic [1:0] access_size = '0;
  logic busy, data_valid;
  logic [DW-1:0] data_out;
  logic [7:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] wd [16];
  int checks = 0, errors = 0, pulses = 0;
  always #5 clk = ~clk;
  burst_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWID), .DEPTH(DEPTH)) dut (
    .clock(clk), .reset(reset), .address(address), .data_in(data_in),
    .access_size(access_size), .rw(rw), .enable(enable), .busy(busy),
    .data_out(data_out), .data_valid(data_valid)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int baddr(int a, int l, int k);
`ifdef BURST_MEMORY_WRAP_EN
    int m = l * BPW - 1;
    return l > 1 ? ((a & ~m) | ((a + k * BPW) & m)) : a;
`else
    return a + k * BPW;
`endif
  endfunction
  function automatic logic [DW-1:0] model_word(int a);
    logic [DW-1:0] w;
    for (int j = 0; j < BPW; j++) w[DW-1-8*j -: 8] = model[(a + j) & (DEPTH - 1)];
    return w;
  endfunction
  always @(negedge clk) begin
    if (data_valid) begin
      pulses++;
      check("rd_queue_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("rd_data", data_out, exp_q.pop_front());
    end
  end
  task automatic run(input bit w, input logic [1:0] sz, input int a, input bit poke);
    int l;
    int ba;
    l = sz == 2'd0 ? 1 : 1 << (int'(sz) + 1);
    enable = 1'b1; rw = w; access_size = sz; address = a;
    for (int k = 0; k < l; k++) begin
      ba = baddr(a, l, k);
      data_in = wd[k];
      if (w) for (int j = 0; j < BPW; j++) model[(ba + j) & (DEPTH - 1)] = wd[k][DW-1-8*j -: 8];
      else exp_q.push_back(model_word(ba));
      @(negedge clk);
      enable = 1'b0;
      if (poke && k == 1) begin
        enable = 1'b1; rw = 1'b0; access_size = 2'b01; address = 32'h40;
      end
      check($sformatf("busy_beat%0d_len%0d", k, l), busy, k < l - 1);
    end
    enable = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", data_valid, 0);
    check("rst_dout", data_out, 0);
    reset = 1'b0;
    wd[0] = 32'hDEADBEEF;
    run(1'b1, 2'd0, 'h100, 1'b0);
    run(1'b0, 2'd0, 'h100, 1'b0);
    @(negedge clk);
    check("single_valid_one_cycle", data_valid, 0);
    check("dout_hold", data_out, 32'hDEADBEEF);
    check("byte_100", dut.mem[256], 8'hDE);
    for (int k = 0; k < 16; k++) wd[k] = k;
    run(1'b1, 2'd3, 'h200, 1'b0);
    run(1'b0, 2'd3, 'h200, 1'b0);
    @(negedge clk);
    pulses = 0;
    run(1'b0, 2'd2, 'h200, 1'b1);
    @(negedge clk);
    check("valid_pulses", pulses, 8);
    check("sb_drain", exp_q.size(), 0);
    wd[0] = 32'h12345678;
    run(1'b1, 2'd0, 'h30C, 1'b0);
    for (int k = 0; k < 16; k++) wd[k] = 32'hA0 + k;
    enable = 1'b1; rw = 1'b1; access_size = 2'd2; address = 'h300; data_in = wd[0];
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < BPW; j++) model['h300 + 4 * k + j] = wd[k][DW-1-8*j -: 8];
      @(negedge clk);
      enable = 1'b0;
      data_in = wd[k + 1];
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", data_valid, 0);
    check("abort_dout", data_out, 0);
    reset = 1'b0;
    run(1'b0, 2'd1, 'h300, 1'b0);
    @(negedge clk);
    wd[0] = 32'h11223344;
    run(1'b1, 2'd0, DEPTH - 4, 1'b0);
    wd[0] = 32'h55667788;
    run(1'b1, 2'd0, 0, 1'b0);
    run(1'b0, 2'd0, DEPTH - 2, 1'b0);
    @(negedge clk);
    check("unaligned_top_wrap", data_out, 32'h33445566);
    for (int k = 0; k < 16; k++) wd[k] = 32'hC0 + k;
    run(1'b1, 2'd3, 0, 1'b0);
    run(1'b0, 2'd1, 'h18, 1'b0);
    @(negedge clk);
`ifdef BURST_MEMORY_WRAP_EN
    check("wrap_last_word", data_out, 32'hC5);
`else
    check("linear_last_word", data_out, 32'hC9);
`endif
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/burst_memory.md
# burst_memory

Parametrised byte-addressable memory with single-word and 4/8/16-word burst read/write transfers, a `busy` handshake and a registered read-data strobe. It is the next-generation instruction/data memory model for the MIPS pipeline testbenches. It is generalised in data width and depth, and adds write bursts, a synchronous reset, and an optional cache-line wrap mode.

## Interface
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8. `BPW = DATA_WIDTH/8` bytes per word.
- `ADDR_WIDTH`, 32: address bus width.
- `DEPTH`, 1048576: memory size in bytes; must be a power of two.
- `clock`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: reset is synchronous and active-high.
- `address`  in  ADDR_WIDTH: byte address of the first beat; sampled only on command accept.
- `data_in`  in  DATA_WIDTH: write data for one beat, sampled every write-beat edge.
- `access_size`  in  2: burst length. 00 = 1 word, 01 = 4, 10 = 8, 11 = 16.
- `rw`  in  1: 1 = write, 0 = read; sampled on accept.
- `enable`  in  1: command request.
- `busy`  out  1: burst in progress; new commands are ignored while high.
- `data_out`  out  DATA_WIDTH: read word, big-endian. The byte at the beat address sits in the MSBs.
- `data_valid`  out  1: `data_out` holds a fresh read beat this cycle.

## Operation
- States: IDLE and BURST. Registers hold the current byte address, the remaining beat count (5 bits), latched `rw`, and the burst base address.
- Accept occurs when `enable && !busy` at a rising edge while in IDLE. Burst length is L = 1/4/8/16.
- Every active beat is performed at its edge:
  - Write beat: `mem[a+k] <= data_in[DATA_WIDTH-1-8k -: 8]` for k = 0..BPW-1.
  - Read beat: `data_out` loads the bytes `mem[a..a+BPW-1]` in big-endian order, and `data_valid <= 1`.
- After each beat, the address advances by BPW. The beat count decrements.
- Beat 0 is performed at the accept edge.
  - L = 1: the FSM stays in IDLE.
  - L > 1: the FSM enters BURST with count = L-1.
  - In BURST, one beat is performed per edge. After the final beat, the FSM returns to IDLE.
- `enable`, `rw`, `access_size` and `address` are ignored in BURST. `data_in` is still sampled on write beats.
- Unaligned addresses are legal; bytes are accessed linearly from the start address.
- All byte addresses are taken modulo DEPTH, so the top of memory wraps to byte 0.
- Memory contents are not cleared by reset and are initially X.

## Timing
- Reset values: `busy` = 0, `data_valid` = 0, `data_out` = 0, state = IDLE, count = 0.
- Read latency: beat k of a burst accepted at edge N is on `data_out` with `data_valid` = 1 in the cycle after edge N+k.
- `data_valid` falls after the last beat. `data_out` holds its last value while `data_valid` is 0.
- Write beat k commits at edge N+k and is readable by a command accepted at edge N+k+1 or later.
- `busy` is registered:
  - It is high in the cycles after edges N .. N+L-2, i.e. L-1 cycles.
  - It is never asserted for L = 1.
- Back-to-back accept is possible at edge N+L, giving 100% bus utilisation.
- Reset asserted mid-burst aborts the burst at that edge:
  - No beat is performed at that edge.
  - Beats already written are retained.
  - All outputs return to their reset values the next cycle.
- Reset has priority over `enable` in the same cycle.

## Configuration
- `BURST_MEMORY_WRAP_EN` defined: bursts with L > 1 wrap within the naturally aligned L·BPW-byte block containing `address` (critical-word-first).
  - The next address is `(base & ~(L·BPW-1)) | ((a+BPW) & (L·BPW-1))`, where `base` is the latched start address.
  - Example: 4-word burst at 0x18 with BPW = 4 accesses 0x18, 0x1C, 0x10, 0x14.
- Not defined: bursts increment linearly. The same example accesses 0x18, 0x1C, 0x20, 0x24. No wrap logic is synthesised.

## Test plan
- Reset, then single write of 0xDEADBEEF to 0x100, then single read of 0x100.
  - Required: `data_out` = 0xDEADBEEF with `data_valid` for 1 cycle.
  - Required: `busy` never rises.
  - Required: byte 0x100 = 0xDE.
- 16-word write burst at 0x200 with `data_in` = 0..15 per beat, then a 16-word read burst at 0x200.
  - Required: `busy` is high for 15 cycles on each burst.
  - Required: reads return 0..15 on consecutive cycles.
  - Required: the next command is accepted at edge N+16.
- 4-word read issued while `busy` is high from a prior 8-word burst.
  - Required: the command is ignored.
  - Required: exactly 8 `data_valid` pulses appear.
- Assert `reset` at beat 3 of an 8-word write burst at 0x300 with data 0xA0..0xA7.
  - Required: outputs are 0 the next cycle.
  - Required: a later read shows 0x300..0x308 holding 0xA0..0xA2, and 0x30C is unchanged.
- Unaligned single read at DEPTH-2 after writing bytes there and at 0.
  - Required: `data_out` = {mem[DEPTH-2], mem[DEPTH-1], mem[0], mem[1]}.
- With `BURST_MEMORY_WRAP_EN`, a 4-word read at 0x18.
  - Required: words from 0x18, 0x1C, 0x10, 0x14 in order.
  - Without the macro: 0x18, 0x1C, 0x20, 0x24.
